dsk_track_prefetch: RTL
=======================

# dsk_track_prefetch

Consumer end of the disk-image slot interface: generates the byte address the memory controller reads during its floppy extra slot. On each granted slot it captures the returned 16-bit word into an 8-byte FIFO. The FIFO drains one byte at a time to the IWM drive model. One instance serves each drive (internal/external); the track wraps circularly so the drive model sees an endless rotating track.

## Interface
- No parameters.
- clk  in  1  system clock (4× clk8, same clock as memory controller)
- reset  in  1  asynchronous, active-high
- memoryLatch  in  1  memory read data valid this clk (last phase of bus cycle)
- dskReadAck  in  1  this instance owns the current extra slot (held for the whole 4-clk bus cycle)
- memoryDataIn  in  16  RAM/ROM read data; [15:8] = even byte
- restart  in  1  one-clk pulse: load new track and flush
- trackStart  in  22  byte offset of track within the disk image, sampled on restart; bit 0 ignored
- trackLen  in  16  track length in bytes, sampled on restart; bit 0 ignored
- dskReadAddr  out  22  byte address of next word to fetch (always even)
- byteOut  out  8  FIFO head byte
- byteValid  out  1  FIFO non-empty
- byteReq  in  1  pop head byte
- underrun  out  1  sticky: byteReq seen while byteValid=0; cleared by restart

## Operation
- State: base (22 b), len (16 b, even), offset (16 b, even), FIFO of 8 bytes with 4-bit count (0..8), underrun flag.
- Reset: base=0, len=0, offset=0, count=0; dskReadAddr=0, byteOut=0, byteValid=0, underrun=0. With len=0, no captures ever occur; the block is idle until the first restart.
- Fetch: a capture occurs when dskReadAck && memoryLatch && len≠0 && count≤6 && !restart.
  - On capture, push memoryDataIn[15:8], then memoryDataIn[7:0].
  - Advance offset by 2. If offset+2 ≥ len, offset becomes 0 (wrap).
- Slots that arrive while count>6 are skipped: no capture and no offset advance. The same address is re-presented on the next slot.
- dskReadAddr = base + offset, registered, mod 2^22 (carry out dropped). It is stable for the whole slot and never changes while dskReadAck is high except on the clk after capture or restart.
- Drain: byteOut is the head byte whenever byteValid=1.
  - byteReq && byteValid pops one byte.
  - byteReq && !byteValid sets underrun. This does not change the FIFO.
- Simultaneous capture and pop in one clk: the count changes by +2−1 = +1. The FIFO order is preserved.
- Restart:
  - Load base=trackStart&~1 and len=trackLen&~1.
  - Set offset=0, count=0, byteValid=0, underrun=0.
  - Restart has priority over a same-clk capture (data discarded) and over a same-clk pop (ignored).
- len=2: every capture refetches the word at base; offset stays 0.

## Timing
- Capture → byteValid/byteOut update on the next clk edge. The first byte is available 1 clk after memoryLatch.
- Capture → dskReadAddr advances on the next clk edge.
- Pop → the next head byte appears on byteOut on the next clk edge.
- Restart → dskReadAddr = trackStart&~1 on the next clk edge. byteValid is 0 from the next clk.
- Throughput is bounded by slot rate: 2 bytes per granted slot. The FIFO holds up to 4 words.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then restart with trackStart=0x00400 and trackLen=0x0008. Feed 4 slots with data 0x1122, 0x3344, 0x5566, 0x7788.
  - dskReadAddr sequence: 0x400, 0x402, 0x404, 0x406.
  - byteOut drains 11,22,33,44,55,66,77,88.
- Wrap: same track, drain continuously over 6 slots. The address after 0x406 is 0x400; the 5th word is fetched from 0x400.
- Full: no byteReq, 5 slots. Only 4 captures occur (count=8). The 5th slot does not capture and dskReadAddr stays 0x400.
  - Pop 2 bytes. The next slot captures from 0x400.
- Simultaneous: count=1 and byteReq on the memoryLatch clk of a capture. Count becomes 2, with the correct order: old byte, then new high byte.
- Restart during slot: restart asserted on the memoryLatch clk with trackStart=0x3FFFFF and trackLen=0x0003.
  - No capture occurs; byteValid=0; underrun is cleared.
  - dskReadAddr=0x3FFFFE next clk; len=2.
- Underrun and reset: byteReq with the FIFO empty sets underrun=1. Asserting reset mid-operation returns all outputs to 0 asynchronously, and no captures occur until restart.

Source files
------------

// File: rtl/dsk_track_prefetch_if.sv
// Disk-image slot bus between the memory controller / IWM drive model and one
// track prefetcher instance.
interface dsk_track_prefetch_if;
  logic        memoryLatch;
  logic        dskReadAck;
  logic [15:0] memoryDataIn;
  logic        restart;
  logic [21:0] trackStart;
  logic [15:0] trackLen;
  logic [21:0] dskReadAddr;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteReq;
  logic        underrun;

  modport master (
    output memoryLatch, dskReadAck, memoryDataIn, restart, trackStart, trackLen, byteReq,
    input  dskReadAddr, byteOut, byteValid, underrun
  );

  modport slave (
    input  memoryLatch, dskReadAck, memoryDataIn, restart, trackStart, trackLen, byteReq,
    output dskReadAddr, byteOut, byteValid, underrun
  );
endinterface

// File: rtl/dsk_track_prefetch.sv
// Fetches a circular disk track one word per granted memory slot and hands it
// to the drive model a byte at a time through an 8-byte shift FIFO.
module dsk_track_prefetch (
  input logic             clk,
  input logic             reset,
  dsk_track_prefetch_if.slave bus
);

  logic [21:0] r_base;
  logic [15:0] r_len;
  logic [15:0] r_offset;
  logic [21:0] r_addr;
  logic [7:0]  r_fifo [8];
  logic [3:0]  r_count;
  logic        r_byteValid;
  logic        r_underrun;

  logic        w_pop;
  logic        w_capture;
  logic [16:0] w_offSum;
  logic [15:0] w_offsetNext;
  logic [3:0]  w_wrIdx;
  logic [3:0]  w_countNext;
  logic [7:0]  w_fifoNext [8];

  assign bus.dskReadAddr = r_addr;
  assign bus.byteOut     = r_fifo[0];
  assign bus.byteValid   = r_byteValid;
  assign bus.underrun    = r_underrun;

  // Entry 0 is always the head; a pop shifts everything down before the
  // captured word is appended behind the surviving bytes.
  always_comb begin
    w_pop        = bus.byteReq && r_byteValid;
    w_capture    = bus.dskReadAck && bus.memoryLatch && (r_len != 16'd0) &&
                   (r_count <= 4'd6) && !bus.restart;
    w_offSum     = {1'b0, r_offset} + 17'd2;
    w_offsetNext = (w_offSum >= {1'b0, r_len}) ? 16'd0 : w_offSum[15:0];
    w_wrIdx      = r_count - {3'd0, w_pop};
    w_countNext  = w_wrIdx + (w_capture ? 4'd2 : 4'd0);
    for (int i = 0; i < 7; i++) begin
      w_fifoNext[i] = w_pop ? r_fifo[i+1] : r_fifo[i];
    end
    w_fifoNext[7] = w_pop ? 8'd0 : r_fifo[7];
    if (w_capture) begin
      w_fifoNext[w_wrIdx[2:0]]        = bus.memoryDataIn[15:8];
      w_fifoNext[w_wrIdx[2:0] + 3'd1] = bus.memoryDataIn[7:0];
    end
  end

  // Restart wins over a same-clock capture or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= 22'd0;
      r_len       <= 16'd0;
      r_offset    <= 16'd0;
      r_addr      <= 22'd0;
      r_count     <= 4'd0;
      r_byteValid <= 1'b0;
      r_underrun  <= 1'b0;
      for (int i = 0; i < 8; i++) r_fifo[i] <= 8'd0;
    end else if (bus.restart) begin
      r_base      <= bus.trackStart & 22'h3FFFFE;
      r_len       <= bus.trackLen & 16'hFFFE;
      r_offset    <= 16'd0;
      r_addr      <= bus.trackStart & 22'h3FFFFE;
      r_count     <= 4'd0;
      r_byteValid <= 1'b0;
      r_underrun  <= 1'b0;
      for (int i = 0; i < 8; i++) r_fifo[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) r_fifo[i] <= w_fifoNext[i];
      r_count     <= w_countNext;
      r_byteValid <= (w_countNext != 4'd0);
      if (bus.byteReq && !r_byteValid) r_underrun <= 1'b1;
      if (w_capture) begin
        r_offset <= w_offsetNext;
        r_addr   <= r_base + {6'd0, w_offsetNext};
      end
    end
  end

endmodule
